// File: rtl/hs32_reg_arb_if.sv
// hs32_reg_arb_if
// Bundles the two requester ports, the completion/read-data returns and the
// register-file port signals of the hs32 register-file arbiter.
//   slave  : arbiter view (requests and rf read data in; grants/rf controls out)
//   master : environment view (requesters + register file)
// Parameters: DATA_W register data width, ADDR_W register address width.
interface hs32_reg_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              a_req, a_lock, a_we;
    logic [ADDR_W-1:0] a_wadr, a_radr1, a_radr2;
    logic [DATA_W-1:0] a_din;
    logic              b_req, b_lock, b_we;
    logic [ADDR_W-1:0] b_wadr, b_radr1, b_radr2;
    logic [DATA_W-1:0] b_din;

    logic              done_a, done_b;
    logic [DATA_W-1:0] rdout1, rdout2;
    logic              locked_a, locked_b;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wadr, rf_radr1, rf_radr2;
    logic [DATA_W-1:0] rf_din, rf_dout1, rf_dout2;

    modport slave (
        input  a_req, a_lock, a_we, a_wadr, a_din, a_radr1, a_radr2,
        input  b_req, b_lock, b_we, b_wadr, b_din, b_radr1, b_radr2,
        input  rf_dout1, rf_dout2,
        output done_a, done_b, rdout1, rdout2, locked_a, locked_b,
        output rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2
    );

    modport master (
        output a_req, a_lock, a_we, a_wadr, a_din, a_radr1, a_radr2,
        output b_req, b_lock, b_we, b_wadr, b_din, b_radr1, b_radr2,
        output rf_dout1, rf_dout2,
        input  done_a, done_b, rdout1, rdout2, locked_a, locked_b,
        input  rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2
    );
endinterface

// File: rtl/hs32_reg_arb.sv
// hs32_reg_arb
// Shares the hs32 register file's write port and two read ports between
// requester A (execute stage) and requester B (debug/irq save-restore).
// One op is issued at a time; completion is a one-cycle done pulse with read
// data on rdout1/2. A requester may keep the grant across up to MAX_HOLD ops
// by holding its lock input.
// Ports:
//   clk   : system clock, all state on posedge
//   reset : asynchronous active-low reset
//   bus   : hs32_reg_arb_if.slave (requests, done/rdout/locked, rf_* port)
//
// state  | meaning
// IDLE   | no op in flight, no lock; round-robin between requesters
// BUSY   | issue cycle: rf_* driven, register file acts at the negedge
// LOCKED | previous owner retains the grant; other requester waits
module hs32_reg_arb #(
    parameter int MAX_HOLD = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input logic           clk,
    input logic           reset,
    hs32_reg_arb_if.slave bus
);
    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_b_q, owner_b_d;
    logic              last_b_q, last_b_d;
    logic              from_lock_q, from_lock_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_wadr_q, rf_wadr_d;
    logic [ADDR_W-1:0] rf_radr1_q, rf_radr1_d;
    logic [ADDR_W-1:0] rf_radr2_q, rf_radr2_d;
    logic [DATA_W-1:0] rf_din_q, rf_din_d;
    logic [DATA_W-1:0] rdout1_q, rdout1_d;
    logic [DATA_W-1:0] rdout2_q, rdout2_d;
    logic              done_a_q, done_a_d;
    logic              done_b_q, done_b_d;

    logic owner_req, owner_lock;
    logic grant, grant_b;

    assign owner_req  = owner_b_q ? bus.b_req  : bus.a_req;
    assign owner_lock = owner_b_q ? bus.b_lock : bus.a_lock;

    always_comb begin
        state_d     = state_q;
        owner_b_d   = owner_b_q;
        last_b_d    = last_b_q;
        from_lock_d = from_lock_q;
        hold_cnt_d  = hold_cnt_q;
        rf_we_d     = 1'b0;
        rf_wadr_d   = rf_wadr_q;
        rf_radr1_d  = rf_radr1_q;
        rf_radr2_d  = rf_radr2_q;
        rf_din_d    = rf_din_q;
        rdout1_d    = rdout1_q;
        rdout2_d    = rdout2_q;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        grant       = 1'b0;
        grant_b     = owner_b_q;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant   = 1'b1;
                    // B wins only if alone or if A was served last
                    grant_b = bus.b_req && (!bus.a_req || !last_b_q);
                end
            end
            LOCKED: begin
                if (owner_req) begin
                    grant   = 1'b1;
                    grant_b = owner_b_q;
                end else if (!owner_lock) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                done_a_d = !owner_b_q;
                done_b_d = owner_b_q;
                // the register file suppresses reads during a write
                if (!rf_we_q) begin
                    rdout1_d = bus.rf_dout1;
                    rdout2_d = bus.rf_dout2;
                end
                last_b_d = owner_b_q;
                if (owner_lock && (hold_cnt_q < HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                    state_d    = LOCKED;
                end else begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d     = BUSY;
            owner_b_d   = grant_b;
            from_lock_d = (state_q == LOCKED);
            rf_we_d     = grant_b ? bus.b_we    : bus.a_we;
            rf_wadr_d   = grant_b ? bus.b_wadr  : bus.a_wadr;
            rf_din_d    = grant_b ? bus.b_din   : bus.a_din;
            rf_radr1_d  = grant_b ? bus.b_radr1 : bus.a_radr1;
            rf_radr2_d  = grant_b ? bus.b_radr2 : bus.a_radr2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_b_q   <= 1'b0;
            last_b_q    <= 1'b1;
            from_lock_q <= 1'b0;
            hold_cnt_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_wadr_q   <= '0;
            rf_radr1_q  <= '0;
            rf_radr2_q  <= '0;
            rf_din_q    <= '0;
            rdout1_q    <= '0;
            rdout2_q    <= '0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_b_q   <= owner_b_d;
            last_b_q    <= last_b_d;
            from_lock_q <= from_lock_d;
            hold_cnt_q  <= hold_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_wadr_q   <= rf_wadr_d;
            rf_radr1_q  <= rf_radr1_d;
            rf_radr2_q  <= rf_radr2_d;
            rf_din_q    <= rf_din_d;
            rdout1_q    <= rdout1_d;
            rdout2_q    <= rdout2_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
        end
    end

    assign bus.done_a   = done_a_q;
    assign bus.done_b   = done_b_q;
    assign bus.rdout1   = rdout1_q;
    assign bus.rdout2   = rdout2_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_wadr  = rf_wadr_q;
    assign bus.rf_din   = rf_din_q;
    assign bus.rf_radr1 = rf_radr1_q;
    assign bus.rf_radr2 = rf_radr2_q;

    // lock is visible while waiting in LOCKED and during ops issued from it
    assign bus.locked_a = !owner_b_q &&
                          ((state_q == LOCKED) || ((state_q == BUSY) && from_lock_q));
    assign bus.locked_b = owner_b_q &&
                          ((state_q == LOCKED) || ((state_q == BUSY) && from_lock_q));
endmodule

// File: tb/tb_hs32_reg_arb.sv
// tb_hs32_reg_arb
// Bench for hs32_reg_arb: a register-file model on the rf_* port, directed
// scenarios with literal expectations, then randomized requesters. An
// op-level reference model predicts done/rdout/locked/rf_we every cycle.
module tb_hs32_reg_arb;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hs32_reg_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hs32_reg_arb #(.MAX_HOLD(MAX_HOLD), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // requester drive, index 0 = A, 1 = B
    logic              req [2];
    logic              lock[2];
    logic              we  [2];
    logic [ADDR_W-1:0] wadr[2];
    logic [ADDR_W-1:0] r1  [2];
    logic [ADDR_W-1:0] r2  [2];
    logic [DATA_W-1:0] din [2];

    assign bus.a_req = req[0];   assign bus.b_req = req[1];
    assign bus.a_lock = lock[0]; assign bus.b_lock = lock[1];
    assign bus.a_we = we[0];     assign bus.b_we = we[1];
    assign bus.a_wadr = wadr[0]; assign bus.b_wadr = wadr[1];
    assign bus.a_radr1 = r1[0];  assign bus.b_radr1 = r1[1];
    assign bus.a_radr2 = r2[0];  assign bus.b_radr2 = r2[1];
    assign bus.a_din = din[0];   assign bus.b_din = din[1];

    logic [DATA_W-1:0] rf_d1, rf_d2;
    logic [DATA_W-1:0] rf_mem[16];
    assign bus.rf_dout1 = rf_d1;
    assign bus.rf_dout2 = rf_d2;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] init_val(input int i);
        if (i == 3) return 32'hDEAD_BEEF;
        if (i == 5) return 32'h1234_5678;
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // register file: writes and reads both happen at the negedge
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = init_val(i);
        rf_d1 = '0;
        rf_d2 = '0;
        forever begin
            @(negedge clk);
            if (bus.rf_we) rf_mem[bus.rf_wadr] = bus.rf_din;
            else begin
                rf_d1 = rf_mem[bus.rf_radr1];
                rf_d2 = rf_mem[bus.rf_radr2];
            end
        end
    end

    // ---------------- reference model (op level) ----------------
    logic [31:0]       m_mem[16];
    int                m_lock_owner;   // -1 none, else requester holding the grant
    int                m_hold;         // ops completed under the current lock
    int                m_last;         // requester served most recently
    bit                m_inflight;
    int                m_owner;
    bit                m_we;
    logic [ADDR_W-1:0] m_wadr, m_r1, m_r2;
    logic [DATA_W-1:0] m_din;
    bit                e_done_a, e_done_b, e_rf_we, e_rd_issue;
    logic [DATA_W-1:0] e_rd1, e_rd2;

    task automatic model_reset();
        m_lock_owner = -1;
        m_hold = 0;
        m_last = 1;
        m_inflight = 0;
        m_owner = 0;
        e_done_a = 0; e_done_b = 0; e_rf_we = 0; e_rd_issue = 0;
        e_rd1 = '0; e_rd2 = '0;
    endtask

    task automatic model_step();
        int g;
        g = -1;
        e_done_a = 0; e_done_b = 0; e_rf_we = 0; e_rd_issue = 0;
        if (m_inflight) begin
            if (m_owner == 0) e_done_a = 1; else e_done_b = 1;
            if (m_we) m_mem[m_wadr] = m_din;
            else begin
                e_rd1 = m_mem[m_r1];
                e_rd2 = m_mem[m_r2];
            end
            m_last = m_owner;
            if (lock[m_owner] && (m_hold + 1 < MAX_HOLD)) begin
                m_hold++;
                m_lock_owner = m_owner;
            end else begin
                m_hold = 0;
                m_lock_owner = -1;
            end
            m_inflight = 0;
        end else begin
            if (m_lock_owner >= 0) begin
                if (req[m_lock_owner]) g = m_lock_owner;
                else if (!lock[m_lock_owner]) begin
                    m_lock_owner = -1;
                    m_hold = 0;
                end
            end else if (req[0] && req[1]) g = 1 - m_last;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
            if (g >= 0) begin
                m_inflight = 1;
                m_owner = g;
                m_we = we[g];
                m_wadr = wadr[g];
                m_din = din[g];
                m_r1 = r1[g];
                m_r2 = r2[g];
                e_rf_we = we[g];
                e_rd_issue = !we[g];
            end
        end
    endtask

    // compare process: model advances on each edge, DUT checked 1 time unit later
    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_reset(); else model_step();
            #1;
            chk("done_a", 32'(bus.done_a), 32'(e_done_a));
            chk("done_b", 32'(bus.done_b), 32'(e_done_b));
            chk("rdout1", bus.rdout1, e_rd1);
            chk("rdout2", bus.rdout2, e_rd2);
            chk("locked_a", 32'(bus.locked_a), 32'(m_lock_owner == 0));
            chk("locked_b", 32'(bus.locked_b), 32'(m_lock_owner == 1));
            chk("rf_we", 32'(bus.rf_we), 32'(e_rf_we));
            if (e_rf_we) begin
                chk("rf_wadr", 32'(bus.rf_wadr), 32'(m_wadr));
                chk("rf_din", bus.rf_din, m_din);
            end
            if (e_rd_issue) begin
                chk("rf_radr1", 32'(bus.rf_radr1), 32'(m_r1));
                chk("rf_radr2", 32'(bus.rf_radr2), 32'(m_r2));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input bit w, input int wa, input logic [31:0] d,
                          input int a1, input int a2, input bit lk);
        req[i] = 1'b1; we[i] = w; wadr[i] = ADDR_W'(wa); din[i] = d;
        r1[i] = ADDR_W'(a1); r2[i] = ADDR_W'(a2); lock[i] = lk;
    endtask

    task automatic drop(input int i);
        req[i] = 1'b0;
        lock[i] = 1'b0;
    endtask

    // waits for a done pulse; who=-1 accepts either. lat=99 on timeout.
    task automatic wait_done(input int who, output int got, output int lat, output int wec);
        bit seen;
        seen = 0; lat = 99; wec = 0; got = -1;
        for (int n = 1; n <= 30; n++) begin
            if (!seen) begin
                tick();
                if (bus.rf_we) wec++;
                if (bus.done_a && (who != 1)) begin seen = 1; got = 0; lat = n; end
                else if (bus.done_b && (who != 0)) begin seen = 1; got = 1; lat = n; end
            end
        end
    endtask

    int  got, lat, wec;
    bit  pending[2];
    bit  d_i;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; lock[i] = 0; we[i] = 0; wadr[i] = '0;
            r1[i] = '0; r2[i] = '0; din[i] = '0; pending[i] = 0;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_rdout1", bus.rdout1, 32'd0);
        chk("rst_done_a", 32'(bus.done_a), 32'd0);
        chk("rst_locked_b", 32'(bus.locked_b), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);

        // A reads r3, r5
        set_op(0, 0, 0, 32'd0, 3, 5, 0);
        wait_done(0, got, lat, wec);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_rdout1", bus.rdout1, 32'hDEAD_BEEF);
        chk("rd_rdout2", bus.rdout2, 32'h1234_5678);
        chk("rd_no_we", 32'(wec), 32'd0);
        drop(0);
        tick();

        // A writes r7, then reads it back straight from the done cycle
        set_op(0, 1, 7, 32'hCAFE_F00D, 0, 0, 0);
        wait_done(0, got, lat, wec);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_we_cycles", 32'(wec), 32'd1);
        chk("wr_rdout_hold", bus.rdout1, 32'hDEAD_BEEF);
        set_op(0, 0, 0, 32'd0, 7, 3, 0);
        wait_done(0, got, lat, wec);
        chk("rb_lat", 32'(lat), 32'd2);
        chk("rb_rdout1", bus.rdout1, 32'hCAFE_F00D);
        chk("rb_rdout2", bus.rdout2, 32'hDEAD_BEEF);
        drop(0);
        tick();

        // from reset, both request continuously: A,B,A,B...
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_op(0, 0, 0, 32'd0, 3, 5, 0);
        set_op(1, 0, 0, 32'd0, 5, 3, 0);
        for (int k = 0; k < 8; k++) begin
            wait_done(-1, got, lat, wec);
            chk("alt_who", 32'(got), 32'(k % 2));
            chk("alt_lat", 32'(lat), 32'd2);
        end
        drop(0); drop(1);
        tick();

        // A locks for two ops, then releases with B waiting
        set_op(0, 0, 0, 32'd0, 1, 2, 1);
        set_op(1, 0, 0, 32'd0, 2, 1, 0);
        wait_done(0, got, lat, wec);
        chk("la_lat1", 32'(lat), 32'd2);
        chk("la_locked1", 32'(bus.locked_a), 32'd1);
        wait_done(0, got, lat, wec);
        chk("la_lat2", 32'(lat), 32'd2);
        chk("la_locked2", 32'(bus.locked_a), 32'd1);
        drop(0);
        tick();
        chk("la_released", 32'(bus.locked_a), 32'd0);
        wait_done(1, got, lat, wec);
        chk("la_b_lat", 32'(lat + 1), 32'd3);
        drop(1);
        tick();

        // B holds lock with A waiting: four B ops, then A
        set_op(1, 0, 0, 32'd0, 4, 6, 1);
        tick();
        set_op(0, 0, 0, 32'd0, 6, 4, 0);
        for (int k = 0; k < 5; k++) begin
            wait_done(-1, got, lat, wec);
            chk("lb_who", 32'(got), (k < 4) ? 32'd1 : 32'd0);
            chk("lb_locked_b", 32'(bus.locked_b), (k < 3) ? 32'd1 : 32'd0);
            if (k == 3) drop(1);
        end
        drop(0); drop(1);
        tick();

        // reset in the issue cycle of an A write
        set_op(0, 1, 9, 32'h1111_1111, 0, 0, 0);
        tick();
        chk("rw_we_issued", 32'(bus.rf_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rw_we_drop", 32'(bus.rf_we), 32'd0);
        chk("rw_done_a", 32'(bus.done_a), 32'd0);
        chk("rw_rdout1", bus.rdout1, 32'd0);
        chk("rw_rf_din", bus.rf_din, 32'd0);
        drop(0);
        tick();
        tick();
        reset = 1'b1;
        set_op(1, 0, 0, 32'd0, 9, 3, 0);
        wait_done(-1, got, lat, wec);
        chk("rw_b_who", 32'(got), 32'd1);
        chk("rw_b_lat", 32'(lat), 32'd2);
        chk("rw_r9_kept", bus.rdout1, init_val(9));
        chk("rw_b_rdout2", bus.rdout2, 32'hDEAD_BEEF);
        drop(1);
        tick();

        // randomized requesters obeying the handshake
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                d_i = (i == 0) ? bus.done_a : bus.done_b;
                if (pending[i]) begin
                    if (d_i) begin
                        pending[i] = 0;
                        if ($urandom % 2 == 0) begin
                            set_op(i, 1'($urandom), int'($urandom % 16), $urandom,
                                   int'($urandom % 16), int'($urandom % 16), ($urandom % 3) == 0);
                            pending[i] = 1;
                        end else begin
                            req[i] = 0;
                            lock[i] = ($urandom % 4) == 0;
                        end
                    end else if (!(m_inflight && m_owner == i) && ($urandom % 4 == 0)) begin
                        din[i] = $urandom;
                        wadr[i] = ADDR_W'($urandom % 16);
                    end
                end else if ($urandom % 3 == 0) begin
                    set_op(i, 1'($urandom), int'($urandom % 16), $urandom,
                           int'($urandom % 16), int'($urandom % 16), ($urandom % 3) == 0);
                    pending[i] = 1;
                end else begin
                    lock[i] = ($urandom % 6) == 0;
                end
            end
        end
        drop(0); drop(1);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hs32_reg_arb.md
Name: hs32_reg_arb

Overview:
Arbiter and sequencer for the hs32 register file. It shares the file's single write port and two read ports between two requesters: A (CPU execute stage) and B (debug/interrupt save-restore unit). It issues one operation at a time onto the register-file ports and returns completion and read data. It supports a bounded lock for atomic multi-operation sequences.

Parameters:
MAX_HOLD, 4, maximum ops a locking requester may complete before lock is forcibly released (>=1)
DATA_W, 32, register data width
ADDR_W, 4, register address width

Ports:
clk  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-low reset
a_req  in  1  requester A op valid; held until done_a
a_lock  in  1  A requests lock retention after current op
a_we  in  1  A op is write (1) or read (0)
a_wadr  in  ADDR_W  A write address
a_din  in  DATA_W  A write data
a_radr1  in  ADDR_W  A read address 1
a_radr2  in  ADDR_W  A read address 2
b_req, b_lock, b_we, b_wadr, b_din, b_radr1, b_radr2  in  as A  requester B equivalents
done_a  out  1  one-cycle pulse: A op complete
done_b  out  1  one-cycle pulse: B op complete
rdout1  out  DATA_W  read data 1 of completed read op
rdout2  out  DATA_W  read data 2 of completed read op
locked_a  out  1  A holds the lock
locked_b  out  1  B holds the lock
rf_we  out  1  to register file write enable
rf_wadr  out  ADDR_W  to register file write address
rf_din  out  DATA_W  to register file write data
rf_radr1  out  ADDR_W  to register file read address 1
rf_radr2  out  ADDR_W  to register file read address 2
rf_dout1  in  DATA_W  from register file read data 1 (updated on negedge)
rf_dout2  in  DATA_W  from register file read data 2

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; last-served pointer = B, so A wins the first tie; hold_cnt=0; lock owner none. An in-flight op is dropped: no done, rf_we low immediately.
- States: IDLE, BUSY, LOCKED.
- IDLE posedge, any req: pick winner, round-robin (the requester not last served wins ties). Register its we/wadr/din/radr1/radr2 onto rf_* ports, record owner, go BUSY.
- BUSY posedge (issue cycle ended; register file acted at the intervening negedge):
  - Drive rf_we low; pulse done_owner for one cycle.
  - For reads, load rdout1/2 from rf_dout1/2. For writes, rdout1/2 hold their previous values, since the register file suppresses reads while we.
  - Update last-served to owner.
  - If owner_lock=1 and hold_cnt+1 < MAX_HOLD: hold_cnt++, go LOCKED. Otherwise hold_cnt=0 and go IDLE.
- LOCKED: only the owner may be granted.
  - Owner req at posedge: issue as in IDLE and go BUSY.
  - Owner lock=0 with no req: go IDLE, hold_cnt=0.
  - The other requester waits regardless of its req.
- Forced release (hold_cnt reaches MAX_HOLD): enter IDLE. last-served = owner, so the other requester wins if requesting. If the other is not requesting, the owner may be re-granted.
- locked_x is high in LOCKED for the owner, and also in BUSY when that BUSY was entered from LOCKED.
- Latency: req sampled at edge t -> rf ports driven at t -> done high during cycle after edge t+1. Throughput is one op per 2 cycles.
- Handshake: req and operands must stay stable until done. A req still high at the edge closing the done cycle is a new op; a requester drops req or presents its next op during the done cycle.
- Simultaneous A and B req in IDLE resolve round-robin. done_a and done_b are never high together.
- rf_we is high only in the cycle following an issue of a write op; never two consecutive cycles.
- Operand changes while not granted are ignored; only values at the grant edge are used.

Test Plan:
- Reset, then A read r3 (preloaded 0xDEADBEEF), r5 (0x12345678) -> done_a 2 cycles after req; rdout1=0xDEADBEEF, rdout2=0x12345678; rf_we stays 0.
- A writes r7=0xCAFEF00D, then reads r7 -> rf_we high exactly one cycle; first done_a leaves rdout unchanged; second returns 0xCAFEF00D.
- A and B req read continuously from reset -> grants alternate A,B,A,B; done_a and done_b pulses every 2 cycles, never overlapping.
- B holds lock with req, MAX_HOLD=4, A requesting -> B completes 4 ops, then A is granted next; locked_b high through B's 4th op then low.
- A locks for 2 ops then drops lock and req with B requesting -> state returns IDLE, B granted on the next edge.
- Assert reset during BUSY of an A write -> rf_we drops immediately, no done_a, outputs 0; after release, a B read is granted first (A wins only ties, B alone is served).
